// File: rtl/instr_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues fixed-latency imem requests,
// buffers returns in a 2-entry queue and hands them to decode; flushes on redirect.
module instr_fetch_queue #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'h0002
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [15:0] id_pc,
    output logic [15:0] id_pc_next,
    output logic [15:0] id_ir
);

    logic [15:0] fpc_q, fpc_d;
    logic [15:0] ifpc_q, ifpc_d;
    logic        inflight_q, inflight_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  count_q, count_d;
    logic [15:0] qpc_q [2];
    logic [15:0] qpc_d [2];
    logic [15:0] qir_q [2];
    logic [15:0] qir_d [2];
    logic        pop_s, push_s, credit_s;
    logic [2:0]  occ_s;

    // Handshake, request and head outputs
    always_comb begin
        // queued plus in-flight must stay below depth so every return has a slot
        occ_s      = {1'b0, count_q} + {2'b00, inflight_q};
        credit_s   = (occ_s < 3'd2);
        id_valid   = (count_q != 2'd0) & ~redirect;
        pop_s      = id_valid & id_ready;
        push_s     = inflight_q & ~redirect;
        imem_req   = reset & ~redirect & (credit_s | pop_s);
        imem_addr  = fpc_q;
        id_pc      = qpc_q[rd_ptr_q];
        id_ir      = qir_q[rd_ptr_q];
        id_pc_next = id_pc + PC_STEP;
    end

    // Next-state: redirect flushes everything and retargets the fetch PC
    always_comb begin
        fpc_d      = fpc_q;
        ifpc_d     = ifpc_q;
        inflight_d = inflight_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        qpc_d      = qpc_q;
        qir_d      = qir_q;
        if (redirect) begin
            fpc_d      = redirect_pc;
            inflight_d = 1'b0;
            rd_ptr_d   = 1'b0;
            wr_ptr_d   = 1'b0;
            count_d    = 2'd0;
        end else begin
            inflight_d = imem_req;
            if (imem_req) begin
                ifpc_d = fpc_q;
                fpc_d  = fpc_q + PC_STEP;
            end else begin
                ifpc_d = ifpc_q;
            end
            if (push_s) begin
                qpc_d[wr_ptr_q] = ifpc_q;
                qir_d[wr_ptr_q] = imem_rdata;
                wr_ptr_d        = ~wr_ptr_q;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpc_q      <= RESET_PC;
            ifpc_q     <= 16'h0000;
            inflight_q <= 1'b0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            qpc_q[0]   <= 16'h0000;
            qpc_q[1]   <= 16'h0000;
            qir_q[0]   <= 16'h0000;
            qir_q[1]   <= 16'h0000;
        end else begin
            fpc_q      <= fpc_d;
            ifpc_q     <= ifpc_d;
            inflight_q <= inflight_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            qpc_q      <= qpc_d;
            qir_q      <= qir_d;
        end
    end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Buffered instruction-fetch front end for the 16-bit five-stage pipeline, sitting directly upstream of the decode stage. It owns the fetch PC, issues requests to a fixed-latency synchronous instruction memory, and holds returned instructions in a 2-entry queue. It presents them to decode under a valid/ready handshake, and flushes on a taken-branch/jump redirect issued by decode.

## Interface
Parameters:
- RESET_PC, 16'h0000, fetch PC loaded on reset
- PC_STEP, 2, PC increment per instruction (byte-addressed 16-bit instructions)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- imem_req  output  1  fetch request this cycle
- imem_addr  output  16  fetch address (current fetch PC)
- imem_rdata  input  16  instruction; valid exactly one cycle after the cycle imem_req=1
- redirect  input  1  decode resolved a jump/branch taken; flush and refetch
- redirect_pc  input  16  new fetch PC, sampled when redirect=1
- id_ready  input  1  decode accepts head entry this cycle
- id_valid  output  1  head entry valid
- id_pc  output  16  PC of head instruction
- id_pc_next  output  16  id_pc + PC_STEP (mod 2^16)
- id_ir  output  16  head instruction word

## Operation
- State: fetch PC `fpc`; inflight flag plus its PC `ifpc`; 2-entry circular queue of {pc, ir} with read pointer, write pointer and 2-bit count (0..2).
- imem_addr = fpc, always.
- pop = id_valid & id_ready. id_valid = (count != 0) & ~redirect.
- imem_req = ~redirect & ((count + inflight < 2) | pop). The credit check guarantees that a returning instruction always has a queue slot.
- On a request: inflight <= 1, ifpc <= fpc, fpc <= fpc + PC_STEP (16-bit wrap, 16'hFFFE -> 16'h0000). If there is no request: inflight <= 0.
- Return cycle (inflight=1, no redirect): push {ifpc, imem_rdata} at the write pointer.
- Push and pop in the same cycle: count unchanged, both pointers advance. Pop at count=1 with a simultaneous push is legal.
- Redirect (highest priority): id_valid=0 and imem_req=0 this cycle. At the edge, count and both pointers are cleared, inflight is cleared (returning data discarded), and fpc <= redirect_pc. No pop occurs in a redirect cycle regardless of id_ready.
- Head outputs come from the read-pointer entry. id_pc_next is combinational from id_pc. An empty queue still drives the stale head contents, qualified by id_valid=0.
- A redirect_pc LSB of 1 is not checked; it is fetched as given.

## Timing
- Reset asserted (reset=0): fpc=RESET_PC, inflight=0, count=0, pointers=0, queue entries=0. Outputs: imem_req=0, imem_addr=RESET_PC, id_valid=0, id_pc=0, id_pc_next=PC_STEP, id_ir=0. Reset asserted mid-operation discards everything immediately (asynchronous).
- First cycle after reset release (cycle 0): imem_req=1, imem_addr=RESET_PC. imem_rdata arrives in cycle 1 and is pushed at that edge. id_valid=1 in cycle 2.
- Request-to-id_valid latency: 2 cycles. Redirect in cycle R: request to redirect_pc in R+1, id_valid in R+3 with id_pc=redirect_pc.
- Throughput with id_ready held high: one instruction per cycle, sustained.
- With id_ready low: the queue fills to 2, then imem_req drops. When id_ready rises, a request issues in that same cycle.
- No combinational path from imem_rdata to any output. id_ready and redirect reach imem_req combinationally.

## Test plan
- Reset/startup: RESET_PC=16'h0040, id_ready=1, ROM word at addr a = a. Required: id_valid rises in cycle 2; id_pc/id_ir = 0040/0040, 0042/0042, 0044/0044 on consecutive cycles; id_pc_next = id_pc+2.
- Backpressure: id_ready=0 from cycle 2 for 5 cycles. Required: count reaches 2, imem_req=0 until release, id_pc stays 0040; after release, 0040, 0042, 0044 delivered with no loss or duplication.
- Redirect: redirect=1 with redirect_pc=16'h1000 while count=2 and inflight=1. Required: id_valid=0 that cycle, discarded data never appears, the next delivered id_pc is 1000, three cycles after redirect.
- Wrap: RESET_PC=16'hFFFC. Required: delivered id_pc sequence FFFC, FFFE, 0000; id_pc_next at FFFE = 0000.
- Async reset mid-stream: drop reset between clock edges with count=1. Required: id_valid=0 and imem_req=0 immediately; restart matches the startup scenario.
- Randomised id_ready plus occasional redirects, checked against a reference sequence model. Required: in-order delivery and exactly one delivery per fetched address on the surviving path.
